// File: rtl/offtarget_pkg.sv
// Shared constants for the off-target searcher AXI4-Lite register file.
package offtarget_pkg;

    localparam int          NUM_REGS      = 4;

    localparam logic [2:0]  REG_CTRL      = 3'd0;
    localparam logic [2:0]  REG_CFG0      = 3'd1;
    localparam logic [2:0]  REG_CFG1      = 3'd2;
    localparam logic [2:0]  REG_CFG2      = 3'd3;
    localparam logic [2:0]  REG_STATUS    = 3'd4;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/offtarget_reg_bank.sv
// Byte-strobed storage for the four RW control words, one write port and a
// combinational read mux.
module offtarget_reg_bank
    import offtarget_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic [1:0]                 widx_i,
    input  logic [31:0]                wdata_i,
    input  logic [3:0]                 wstrb_i,
    input  logic [1:0]                 ridx_i,
    output logic [31:0]                rdata_o,
    output logic [NUM_REGS-1:0][31:0]  regs_o
);

    logic [NUM_REGS-1:0][31:0] mem_q;

    // Update only the byte lanes whose strobe is set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];
    assign regs_o  = mem_q;

endmodule

// File: rtl/offtarget_axil_regs.sv
// AXI4-Lite slave fronting the off-target searcher core: four RW control
// words, one RO status word, and a one-cycle start pulse.
module offtarget_axil_regs
    import offtarget_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_i,
    output logic                            start_o
);

    logic        armed_q;
    logic        aw_held_q, aw_held_d;
    logic [2:0]  aw_idx_q,  aw_idx_d;
    logic        w_held_q,  w_held_d;
    logic [31:0] w_data_q,  w_data_d;
    logic [3:0]  w_strb_q,  w_strb_d;
    logic        bvalid_q,  bvalid_d;
    logic        start_q,   start_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [2:0]  wr_idx, rd_idx;
    logic [31:0] wr_data, bank_rdata;
    logic [3:0]  wr_strb;
    logic [NUM_REGS-1:0][31:0] regs;

    // PROT and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = armed_q & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = armed_q & ~w_held_q  & ~bvalid_q;
    assign S_AXI_ARREADY = armed_q & ~rvalid_q;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // A channel arriving this cycle bypasses its holding register so the
    // write lands on the edge of whichever handshake completes second.
    assign wr_idx  = aw_hs ? S_AXI_AWADDR[4:2] : aw_idx_q;
    assign wr_data = w_hs  ? S_AXI_WDATA       : w_data_q;
    assign wr_strb = w_hs  ? S_AXI_WSTRB       : w_strb_q;
    assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);

    assign rd_idx  = S_AXI_ARADDR[4:2];

    offtarget_reg_bank u_bank (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .we_i    (commit & (wr_idx < REG_STATUS)),
        .widx_i  (wr_idx[1:0]),
        .wdata_i (wr_data),
        .wstrb_i (wr_strb),
        .ridx_i  (rd_idx[1:0]),
        .rdata_o (bank_rdata),
        .regs_o  (regs)
    );

    // Write channel latching, commit and B response.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = S_AXI_WDATA;
                w_strb_d = S_AXI_WSTRB;
            end
            if (bvalid_q && S_AXI_BREADY) begin
                bvalid_d = 1'b0;
            end
        end
        start_d = commit && (wr_idx == REG_CTRL) && wr_strb[0] && wr_data[0];
    end

    // Read response: data is captured at the AR handshake and held until taken.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (rd_idx < REG_STATUS)       rdata_d = bank_rdata;
            else if (rd_idx == REG_STATUS) rdata_d = status_i;
            else                           rdata_d = '0;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers; armed keeps the readys low for the first cycle after reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            armed_q   <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            start_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            armed_q   <= 1'b1;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            start_q   <= start_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_BRESP  = AXI_RESP_OKAY;
    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_RRESP  = AXI_RESP_OKAY;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign start_o      = start_q;
    assign reg0_o       = regs[0];
    assign reg1_o       = regs[1];
    assign reg2_o       = regs[2];
    assign reg3_o       = regs[3];

endmodule
